// File: rtl/input_capture_unit_if.sv
// CPU-side IN handshake: request in, stall/valid/data back out.
interface input_capture_unit_if #(
    parameter int DATA_W = 16
);
    logic              in_req;
    logic              stall;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;

    modport master (output in_req, input stall, in_valid, in_data);
    modport slave  (input in_req, output stall, in_valid, in_data);
endinterface

// File: rtl/input_capture_unit.sv
// Serves the CPU IN instruction: stalls until a debounced press, latches the
// switch word, strobes valid for one cycle; blinks an LED and counts presses.
module input_capture_unit #(
    parameter int DATA_W    = 16,
    parameter int BLINK_DIV = 25,
    parameter int CNT_W     = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_pb_pulse,
    input  logic [DATA_W-1:0]    i_switches,
    input_capture_unit_if.slave  bus,
    output logic                 o_wait_led,
    output logic [CNT_W-1:0]     o_press_cnt
);
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_in_data;
    logic              r_in_valid;
    logic              r_wait_led;
    logic [BW-1:0]     r_blink_cnt;
    logic [CNT_W-1:0]  r_press_cnt;
    logic              w_stall;

    // The CPU must freeze in the very cycle it raises in_req, hence the IDLE term.
    assign w_stall = (r_state == WAIT) || ((r_state == IDLE) && bus.in_req);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_in_data   <= '0;
            r_in_valid  <= 1'b0;
            r_wait_led  <= 1'b0;
            r_blink_cnt <= '0;
            r_press_cnt <= '0;
        end else begin
            r_in_valid <= 1'b0;
            if (i_pb_pulse)
                r_press_cnt <= r_press_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    r_wait_led  <= 1'b0;
                    r_blink_cnt <= '0;
                    if (bus.in_req)
                        r_state <= WAIT;
                end
                WAIT: begin
                    if (!bus.in_req) begin
                        // Abort takes priority over a coincident press.
                        r_state     <= IDLE;
                        r_wait_led  <= 1'b0;
                        r_blink_cnt <= '0;
                    end else if (i_pb_pulse) begin
                        r_state     <= DONE;
                        r_in_data   <= i_switches;
                        r_in_valid  <= 1'b1;
                        r_wait_led  <= 1'b0;
                        r_blink_cnt <= '0;
                    end else if (r_blink_cnt == BLINK_MAX) begin
                        r_blink_cnt <= '0;
                        r_wait_led  <= ~r_wait_led;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_wait_led  <= 1'b0;
                    r_blink_cnt <= '0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_wait_led  <= 1'b0;
                    r_blink_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.stall    = w_stall;
    assign bus.in_valid = r_in_valid;
    assign bus.in_data  = r_in_data;
    assign o_wait_led   = r_wait_led;
    assign o_press_cnt  = r_press_cnt;
endmodule

// File: tb/tb_input_capture_unit.sv
// Directed bench for input_capture_unit; captured words go through a scoreboard
// queue that a negedge monitor drains on every in_valid strobe.
module tb_input_capture_unit;
    localparam int DATA_W    = 16;
    localparam int BLINK_DIV = 4;
    localparam int CNT_W     = 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              pb = 1'b0;
    logic [DATA_W-1:0] sw = '0;
    logic              wait_led;
    logic [CNT_W-1:0]  press_cnt;

    input_capture_unit_if #(.DATA_W(DATA_W)) bif ();

    input_capture_unit #(
        .DATA_W(DATA_W), .BLINK_DIV(BLINK_DIV), .CNT_W(CNT_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_pb_pulse  (pb),
        .i_switches  (sw),
        .bus         (bif),
        .o_wait_led  (wait_led),
        .o_press_cnt (press_cnt)
    );

    always #5 clock = ~clock;

    int                n_checks = 0;
    int                n_pass   = 0;
    logic [DATA_W-1:0] sb_q[$];
    logic [CNT_W-1:0]  exp_cnt;
    logic [DATA_W-1:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin : monitor
        logic [DATA_W-1:0] e;
        if (bif.in_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_in_valid: got in_valid=1 data=%0h expected no strobe", bif.in_data);
            end else begin
                e = sb_q.pop_front();
                check("in_data_at_valid", 32'(bif.in_data), 32'(e));
            end
        end
    end

    initial begin
        bif.in_req = 1'b0;

        // Reset with random inputs
        reset_n = 1'b0;
        repeat (2) begin
            pb = 1'($urandom); sw = DATA_W'($urandom); bif.in_req = 1'($urandom);
            tick();
        end
        reset_n = 1'b1; pb = 1'b0; sw = '0; bif.in_req = 1'b0;
        #1;
        check("rst_stall", 32'(bif.stall), 0);
        check("rst_in_valid", 32'(bif.in_valid), 0);
        check("rst_in_data", 32'(bif.in_data), 0);
        check("rst_wait_led", 32'(wait_led), 0);
        check("rst_press_cnt", 32'(press_cnt), 0);
        exp_cnt = '0; exp_data = '0;
        tick();

        // Basic capture: press sampled at the end of cycle 10
        bif.in_req = 1'b1; sw = 16'hA5C3;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) begin
                pb = 1'b1; sb_q.push_back(16'hA5C3); exp_cnt++;
            end
            #1;
            check($sformatf("cap_stall_c%0d", c), 32'(bif.stall), 1);
            tick();
        end
        pb = 1'b0; exp_data = 16'hA5C3;
        check("cap_stall_done", 32'(bif.stall), 0);
        check("cap_valid_done", 32'(bif.in_valid), 1);
        bif.in_req = 1'b0;
        tick();
        check("cap_valid_after", 32'(bif.in_valid), 0);
        check("cap_data_held", 32'(bif.in_data), 32'(exp_data));
        tick(); tick();
        check("cap_idle_stall", 32'(bif.stall), 0);
        check("cap_press_cnt", 32'(press_cnt), 32'(exp_cnt));

        // Blink: WAIT from cycle 1, LED toggles every BLINK_DIV cycles starting 0
        bif.in_req = 1'b1; sw = 16'h1234;
        tick();
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("blink_c%0d", c), 32'(wait_led), 32'(((c - 1) / BLINK_DIV) % 2));
            tick();
        end
        pb = 1'b1; sb_q.push_back(16'h1234); exp_cnt++;
        tick();
        pb = 1'b0; exp_data = 16'h1234;
        check("blink_led_done", 32'(wait_led), 0);
        bif.in_req = 1'b0;
        tick();
        check("blink_led_idle", 32'(wait_led), 0);

        // Abort: press coincides with in_req drop
        bif.in_req = 1'b1; sw = 16'hFFFF;
        repeat (5) tick();
        bif.in_req = 1'b0; pb = 1'b1; exp_cnt++;
        tick();
        pb = 1'b0;
        check("abort_stall", 32'(bif.stall), 0);
        check("abort_led", 32'(wait_led), 0);
        check("abort_in_valid", 32'(bif.in_valid), 0);
        tick();
        check("abort_data", 32'(bif.in_data), 32'(exp_data));
        check("abort_press_cnt", 32'(press_cnt), 32'(exp_cnt));

        // Stray presses in IDLE: 257 high cycles wrap the 8-bit count by +1
        bif.in_req = 1'b0;
        for (int i = 0; i < 257; i++) begin
            pb = 1'b1; sw = DATA_W'(i);
            tick();
        end
        pb = 1'b0; exp_cnt = exp_cnt + 8'd1;
        tick();
        check("stray_press_cnt", 32'(press_cnt), 32'(exp_cnt));
        check("stray_data", 32'(bif.in_data), 32'(exp_data));
        check("stray_stall", 32'(bif.stall), 0);

        // Back-to-back IN with in_req held across DONE
        bif.in_req = 1'b1; sw = 16'h0001;
        tick(); tick(); tick();
        pb = 1'b1; sb_q.push_back(16'h0001); exp_cnt++;
        tick();
        pb = 1'b0; sw = 16'h0002;
        check("b2b_stall_done1", 32'(bif.stall), 0);
        tick();
        check("b2b_stall_reassert", 32'(bif.stall), 1);
        tick();
        pb = 1'b1; sb_q.push_back(16'h0002); exp_cnt++;
        tick();
        pb = 1'b0; bif.in_req = 1'b0; exp_data = 16'h0002;
        check("b2b_stall_done2", 32'(bif.stall), 0);
        tick();
        check("b2b_final_data", 32'(bif.in_data), 32'(exp_data));
        check("b2b_press_cnt", 32'(press_cnt), 32'(exp_cnt));

        // Reset mid-WAIT abandons the request
        bif.in_req = 1'b1; sw = 16'hBEEF;
        tick(); tick(); tick();
        check("rw_stall_wait", 32'(bif.stall), 1);
        reset_n = 1'b0; bif.in_req = 1'b0; pb = 1'b1;
        tick();
        reset_n = 1'b1; pb = 1'b0;
        #1;
        check("rw_stall", 32'(bif.stall), 0);
        check("rw_led", 32'(wait_led), 0);
        check("rw_data", 32'(bif.in_data), 0);
        check("rw_press_cnt", 32'(press_cnt), 0);
        check("rw_in_valid", 32'(bif.in_valid), 0);
        repeat (4) tick();
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/input_capture_unit.md
Name: input_capture_unit

Overview:
- Downstream consumer of the push-button debouncer's single-cycle pulse.
- Serves the CPU's IN instruction. On request, it stalls the CPU until the user presses the debounced "enter" button, then latches the switch word and hands it to the datapath with a one-cycle valid strobe.
- While waiting, it blinks an LED so the user knows input is expected. It also counts presses for debug display.

Parameters:
- DATA_W, 16: width of switch input and captured word.
- BLINK_DIV, 25: number of clock cycles between wait_led toggles while waiting. Legal range is 2 or more.
- CNT_W, 8: width of the press counter.

Ports:
- clock  input  1  system clock. It is the same clock as the debouncer, so pb_pulse is synchronous to it.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- pb_pulse  input  1  debounced one-cycle press pulse.
- switches  input  DATA_W  user switch bank, assumed stable around the press.
- in_req  input  1  CPU is executing IN. Held high until in_valid is seen.
- stall  output  1  freeze the CPU PC/pipeline.
- in_valid  output  1  one-cycle strobe: in_data holds a new word.
- in_data  output  DATA_W  last captured switch word.
- wait_led  output  1  blinking indicator while waiting.
- press_cnt  output  CNT_W  total pb_pulse count, wrapping.

Behaviour:
- Reset (reset_n=0 at a rising edge of clock) applies from the next cycle:
  - state=IDLE, in_data=0, in_valid=0, wait_led=0, press_cnt=0, blink counter=0.
  - Reset mid-WAIT abandons the request with no capture.
- States: IDLE, WAIT, DONE.
- IDLE:
  - in_req=1 → WAIT.
  - stall = in_req (combinational), so the CPU freezes in the same cycle it raises in_req.
  - pb_pulse is ignored for capture.
- WAIT:
  - stall=1.
  - pb_pulse=1 and in_req=1 → in_data<=switches, next state DONE.
  - in_req=0 (abort) → IDLE, no capture. An abort wins over a simultaneous pb_pulse.
- DONE:
  - in_valid=1 (registered, exactly one cycle), stall=0, unconditional → IDLE.
  - If in_req is still high in the cycle after DONE, it is treated as a new request: IDLE→WAIT, stall goes high again.
- Latency: in_valid is high exactly 1 cycle after the clock edge that samples pb_pulse in WAIT. in_data is valid in that same cycle and is held until the next capture.
- wait_led:
  - 0 outside WAIT.
  - On entry to WAIT, wait_led=0 and the blink counter is cleared.
  - The counter increments each WAIT cycle. When it reaches BLINK_DIV-1, wait_led toggles and the counter returns to 0.
  - On leaving WAIT, wait_led and the counter clear on the next edge.
- press_cnt:
  - Increments on every pb_pulse in any state, including stray presses in IDLE.
  - Wraps modulo 2^CNT_W (2^CNT_W-1 → 0).
- pb_pulse held high for several cycles (debouncer misuse) captures only once, because DONE is transient. press_cnt counts every high cycle.
- No combinational path from pb_pulse or switches to any output.

Test Plan:
- Reset: assert reset_n=0 for 2 cycles with random inputs → all outputs 0, state IDLE.
- Basic capture:
  - Stimulus: in_req=1 at cycle 0; switches=16'hA5C3; pb_pulse at cycle 10.
  - Expected: stall=1 for cycles 0–10; in_valid=1 at cycle 11 only; in_data=16'hA5C3 from cycle 11; stall=0 at cycle 11.
  - Then drop in_req → stays IDLE.
- Abort: in_req high 5 cycles then low, with pb_pulse in the same cycle as the drop → no in_valid, in_data unchanged, press_cnt+1, state IDLE.
- Blink: with BLINK_DIV=4, hold WAIT for 20 cycles → wait_led toggles every 4 cycles starting 0. After capture, wait_led=0.
- Stray presses and wrap: CNT_W=8, 257 pb_pulses in IDLE → press_cnt=1, in_valid never asserted, in_data unchanged.
- Back-to-back IN: keep in_req high across DONE and press twice with switches 16'h0001 then 16'h0002 → two single-cycle in_valid strobes, stall re-asserts the cycle after the first DONE, final in_data=16'h0002.
- Reset mid-WAIT: pulse reset_n=0 in WAIT, then release with in_req=0 → IDLE, stall=0, wait_led=0, in_data=0, no in_valid.
